// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Shares the single UART transmit write port among four byte-stream
// requesters. Grants are round-robin and packet-locked: once a requester
// owns the port it keeps it until it presents a byte flagged as last, or
// until it leaves its request low for TIMEOUT cycles while owning the port.
// After each byte is written, one GAP cycle lets tx_full settle before the
// next byte is sampled.
//
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   req[i]   : requester i has a valid byte on its data lane
//   data     : byte lanes, requester i drives data[8*i+7:8*i]
//   last[i]  : the current byte of requester i ends its packet
//   ack[i]   : one-cycle pulse, byte of requester i was written
//   grant    : one-hot current owner, zero when idle
//   busy     : a packet is in progress
//   timeout  : one-cycle pulse, grant revoked because the owner stalled
//   tx_full  : UART TX FIFO full
//   wr_uart  : one-cycle write strobe to the UART
//   w_data   : byte to the UART, valid while wr_uart is high
module uart_tx_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data,
    input  logic [3:0]  last,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        timeout,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    // The stall counter fires on the sample that would bring it to TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [1:0]      owner, owner_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic [3:0]      grant_nxt, ack_nxt;
    logic            busy_nxt, timeout_nxt, wr_nxt;
    logic [7:0]      w_data_nxt;
    logic [1:0]      pick;
    logic            found;
    logic [7:0]      owner_data;

    // Round-robin search: walk the requests starting at the pointer and
    // wrapping around, taking the first one that is set. The 2-bit index
    // wraps on its own.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                found = 1'b1;
                pick  = ptr + 2'(k);
            end
        end
    end

    // Byte lane of the current owner.
    always_comb begin
        owner_data = data[{owner, 3'b000} +: 8];
    end

    // Next-state and next-output logic. Every output is registered, so this
    // block computes what the outputs will show in the following cycle.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        grant_nxt   = grant;
        busy_nxt    = busy;
        ack_nxt     = 4'b0000;
        wr_nxt      = 1'b0;
        w_data_nxt  = w_data;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    grant_nxt = 4'b0001 << pick;
                    busy_nxt  = 1'b1;
                    ptr_nxt   = pick + 2'd1;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (req[owner]) begin
                    // With tx_full high the owner simply waits; the stall
                    // counter only measures time with the request dropped.
                    if (!tx_full) begin
                        wr_nxt     = 1'b1;
                        w_data_nxt = owner_data;
                        ack_nxt    = 4'b0001 << owner;
                        cnt_nxt    = '0;
                        if (last[owner]) begin
                            grant_nxt = 4'b0000;
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = GAP;
                        end
                    end
                end else if (cnt == TO_LAST) begin
                    timeout_nxt = 1'b1;
                    grant_nxt   = 4'b0000;
                    busy_nxt    = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            GAP: begin
                state_nxt = SEND;
            end
            default: begin
                grant_nxt = 4'b0000;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops everything at once, so a
    // packet in flight is abandoned without a trailing write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            owner   <= 2'd0;
            cnt     <= '0;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            ack     <= 4'b0000;
            wr_uart <= 1'b0;
            w_data  <= 8'h00;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            grant   <= grant_nxt;
            busy    <= busy_nxt;
            ack     <= ack_nxt;
            wr_uart <= wr_nxt;
            w_data  <= w_data_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing the single UART transmit write port (wr_uart / w_data / tx_full) among 4 byte-stream requesters.
- Grants are packet-locked: an owner keeps the port until it presents a byte flagged last, or until it stalls past a timeout.
- Sits between the application-side producers (echo path, status reporter, debug monitor, etc.) and the uart module in the system top.

Parameters:
- TIMEOUT, 255: cycles an owner may hold the grant with req low before the grant is revoked (1..65535).
- TO_W, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  4  req[i]: requester i has a valid byte on its data lane
- data  in  32  byte lanes; requester i drives data[8*i+7:8*i]
- last  in  4  last[i]: current byte of requester i ends its packet
- ack  out  4  one-hot, 1-cycle pulse: byte of requester i was written to the UART
- grant  out  4  one-hot current owner; 0 when idle
- busy  out  1  a packet is in progress (grant != 0)
- timeout  out  1  1-cycle pulse: grant revoked by timeout
- tx_full  in  1  UART TX FIFO full
- wr_uart  out  1  write strobe to the UART (1-cycle pulse)
- w_data  out  8  byte to the UART, valid while wr_uart = 1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- All outputs are registered.
- Reset: state = IDLE; ack, grant, busy, timeout, wr_uart = 0; w_data = 0x00; RR pointer = 0, so requester 0 has highest priority. Reset asserted mid-packet aborts the packet immediately; no partial write is issued after reset.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If req != 0, grant the first set req[i] searching from the pointer upward with wrap (ptr, ptr+1, ..., ptr+3 mod 4).
  - Register grant = onehot(i), busy = 1, pointer = (i+1) mod 4, timeout counter = 0, go to SEND.
  - If req == 0, stay in IDLE.
- SEND, owner o:
  - If req[o] && !tx_full: next cycle wr_uart = 1, w_data = data lane o, ack = onehot(o), counter = 0. Go to GAP, or to IDLE (grant = 0, busy = 0) if last[o] was 1 at the sample.
  - If req[o] && tx_full: hold, no write, counter not incremented.
  - If !req[o]: counter++. When counter reaches TIMEOUT, pulse timeout = 1 the next cycle, set grant = 0, busy = 0, go to IDLE.
- GAP: one cycle that lets tx_full settle after a write. wr_uart and ack return to 0, then go back to SEND.
- Throughput: at most 1 byte every 2 cycles per packet.
- Arbitration after a packet costs 1 IDLE cycle.
- Handshake: a requester sees ack[i] high for one cycle and must update data/last (or drop req) on the clock edge that ends that ack cycle. SEND samples the new value on the following cycle.
- Non-owners are ignored while a packet is in progress; their req may stay high indefinitely.
- A lane change during SEND by a non-owner has no effect.
- Simultaneous events:
  - A new req arriving in the same cycle the owner's last byte is sampled is arbitrated in the subsequent IDLE cycle.
  - tx_full rising during GAP is honoured in the next SEND.
- wr_uart is never asserted in a cycle that follows a SEND sample with tx_full = 1.
- At most one ack bit is set at any time; ack and wr_uart are always coincident.

Test Plan:
- Reset then single packet: req[2]=1, bytes 0x41, 0x42, 0x43 with last on 0x43, tx_full=0 -> wr_uart pulses every 2 cycles with w_data 0x41, 0x42, 0x43; ack[2] coincident with each pulse; grant = 0100 until the cycle after the last write, then 0000.
- Round robin: req = 1111, each requester sends a 1-byte packet, repeated -> grant order 0, 1, 2, 3, 0; with req = 1010 after owner 1 -> the next grant is 3, not 1.
- Packet lock: owner 0 sends 4 bytes while req[1] is held high -> no ack[1] and no interleaved bytes until owner 0's last byte; grant moves to 1 only afterwards.
- Backpressure: tx_full=1 for 10 cycles mid-packet -> no wr_uart and no timeout; the first write occurs 1 cycle after tx_full drops, with byte order preserved.
- Timeout: TIMEOUT=8, owner 3 drops req after its first byte -> timeout pulses exactly 8 cycles into the stall (counted in SEND); grant = 0; a pending req[0] is granted on the next IDLE cycle.
- Reset mid-packet: assert reset in SEND with req[1]=1 -> next cycle all outputs 0 and pointer = 0; after release with req = 0011, requester 0 is granted first.
